// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit multiplexed 7-segment scan controller with blanking gaps and frame-aligned loads
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module disp_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic        load,
   output logic        pending,
   output logic        frame_done,
   output logic [3:0]  an,
   output logic [6:0]  seg
);
   localparam int CW = $clog2(REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES);
   localparam logic [CW-1:0] RLAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   disp_q, disp_d, shadow_q, shadow_d;
   logic          pending_q, pending_d, frame_done_q, frame_done_d;
   logic [3:0]    an_q, an_d, nib;
   logic [6:0]    seg_q, seg_d;
   logic          boundary, lzb, show;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // Slot sequencing, frame-aligned value update, and pin values derived from the next state
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q + CW'(1);
      disp_d   = disp_q;
      shadow_d = shadow_q;
      pending_d = pending_q;
      boundary = 1'b0;
      if (state_q == BLANK) begin
         if (cnt_q == BLAST) begin
            cnt_d   = '0;
            state_d = SHOW;
         end
      end else if (cnt_q == RLAST) begin
         cnt_d    = '0;
         state_d  = BLANK;
         idx_d    = idx_q + 2'd1;
         boundary = (idx_q == 2'd3);
      end
      if (boundary && pending_q) begin
         disp_d    = shadow_q;
         pending_d = 1'b0;
      end
      if (load) begin
         shadow_d = value;
         if (frame_done_q) disp_d = value;
         else pending_d = 1'b1;
      end
      nib = disp_d[{idx_d, 2'b00} +: 4];
`ifdef DISP_LZB_EN
      lzb = (idx_d != 2'd0) && ((disp_d >> {idx_d, 2'b00}) == 16'h0);
`else
      lzb = 1'b0;
`endif
      show         = (state_d == SHOW) && !lzb;
      an_d         = show ? ~(4'b0001 << idx_d) : 4'b1111;
      seg_d        = show ? decode(nib) : 7'b1111111;
      frame_done_d = boundary;
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= BLANK;
         idx_q        <= '0;
         cnt_q        <= '0;
         disp_q       <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
         an_q         <= 4'b1111;
         seg_q        <= 7'b1111111;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         disp_q       <= disp_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         frame_done_q <= frame_done_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
      end
   end

   assign pending    = pending_q;
   assign frame_done = frame_done_q;
   assign an         = an_q;
   assign seg        = seg_q;
endmodule
